// File: rtl/cpu_control_if.sv
// Control-unit bus: ROM fetch port, datapath strobes and status flags.
// master = control unit, slave = ROM/datapath side.
interface cpu_control_if;
  logic        run;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        alu_carry;
  logic [7:0]  imm;
  logic        reg_we;
  logic [1:0]  reg_dst;
  logic [1:0]  wsel;
  logic [1:0]  alu_x;
  logic [1:0]  alu_y;
  logic        alu_y_imm;
  logic        out_we;
  logic [1:0]  out_src;
  logic        carry;
  logic        halted;
  logic        illegal;

  modport master (
    input  run, rom_data, alu_carry,
    output rom_addr, imm, reg_we, reg_dst, wsel, alu_x, alu_y, alu_y_imm,
           out_we, out_src, carry, halted, illegal
  );

  modport slave (
    output run, rom_data, alu_carry,
    input  rom_addr, imm, reg_we, reg_dst, wsel, alu_x, alu_y, alu_y_imm,
           out_we, out_src, carry, halted, illegal
  );
endinterface

// File: rtl/cpu_control.sv
// Two-cycle (FETCH/EXECUTE) control unit for the 8-bit CPU: owns pc, ir and
// carry, and decodes ir into datapath strobes.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_FETCH   | latch rom_data into ir when run is high, otherwise stall
// S_EXECUTE | decode ir, drive strobes, update pc/carry
// S_HALT    | self-targeting branch executed; frozen until rst
module cpu_control (
  input  logic              clk,
  input  logic              rst,
  cpu_control_if.master     bus
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_EXECUTE = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  localparam logic [7:0] OP_ADD_AB = 8'h00;
  localparam logic [7:0] OP_ADD_BA = 8'h01;
  localparam logic [7:0] OP_MOV_AI = 8'h22;
  localparam logic [7:0] OP_MOV_BI = 8'h23;
  localparam logic [7:0] OP_MOV_CB = 8'h27;
  localparam logic [7:0] OP_OUT_A  = 8'h2C;
  localparam logic [7:0] OP_OUT_B  = 8'h2D;
  localparam logic [7:0] OP_JNC    = 8'h30;
  localparam logic [7:0] OP_JMP    = 8'h34;
  localparam logic [7:0] OP_INC_C  = 8'h38;

  localparam logic [1:0] R_A = 2'b00;
  localparam logic [1:0] R_B = 2'b01;
  localparam logic [1:0] R_C = 2'b10;

  localparam logic [1:0] W_SUM = 2'b00;
  localparam logic [1:0] W_IMM = 2'b01;
  localparam logic [1:0] W_REGB = 2'b10;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        carry_q, carry_d;

  logic        reg_we;
  logic [1:0]  reg_dst;
  logic [1:0]  wsel;
  logic [1:0]  alu_x;
  logic [1:0]  alu_y;
  logic        alu_y_imm;
  logic        out_we;
  logic [1:0]  out_src;
  logic        illegal;
  logic        branch_taken;

  logic [7:0]  opcode;
  logic [7:0]  operand;

  assign opcode  = ir_q[15:8];
  assign operand = ir_q[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= 8'h00;
      ir_q    <= 16'h0000;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    carry_d      = carry_q;
    reg_we       = 1'b0;
    reg_dst      = R_A;
    wsel         = W_SUM;
    alu_x        = R_A;
    alu_y        = R_A;
    alu_y_imm    = 1'b0;
    out_we       = 1'b0;
    out_src      = R_A;
    illegal      = 1'b0;
    branch_taken = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (bus.run) begin
          ir_d    = bus.rom_data;
          state_d = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        state_d = S_FETCH;
        pc_d    = pc_q + 8'd1;
        case (opcode)
          OP_ADD_AB: begin
            reg_we  = 1'b1;
            reg_dst = R_A;
            wsel    = W_SUM;
            alu_x   = R_A;
            alu_y   = R_B;
            carry_d = bus.alu_carry;
          end
          OP_ADD_BA: begin
            reg_we  = 1'b1;
            reg_dst = R_B;
            wsel    = W_SUM;
            alu_x   = R_B;
            alu_y   = R_A;
            carry_d = bus.alu_carry;
          end
          OP_MOV_AI: begin
            reg_we  = 1'b1;
            reg_dst = R_A;
            wsel    = W_IMM;
          end
          OP_MOV_BI: begin
            reg_we  = 1'b1;
            reg_dst = R_B;
            wsel    = W_IMM;
          end
          OP_MOV_CB: begin
            reg_we  = 1'b1;
            reg_dst = R_C;
            wsel    = W_REGB;
          end
          OP_OUT_A: begin
            out_we  = 1'b1;
            out_src = R_A;
          end
          OP_OUT_B: begin
            out_we  = 1'b1;
            out_src = R_B;
          end
          OP_JNC: begin
            // carry_q is still the value from before this EXECUTE
            if (!carry_q) begin
              pc_d         = operand;
              branch_taken = 1'b1;
            end
          end
          OP_JMP: begin
            pc_d         = operand;
            branch_taken = 1'b1;
          end
          OP_INC_C: begin
            reg_we    = 1'b1;
            reg_dst   = R_C;
            wsel      = W_SUM;
            alu_x     = R_C;
            alu_y_imm = 1'b1;
            carry_d   = bus.alu_carry;
          end
          default: illegal = 1'b1;
        endcase
        if (branch_taken && (operand == pc_q)) begin
          state_d = S_HALT;
        end
      end

      S_HALT: ;

      default: state_d = S_FETCH;
    endcase
  end

  assign bus.rom_addr  = pc_q;
  assign bus.imm       = operand;
  assign bus.carry     = carry_q;
  assign bus.halted    = (state_q == S_HALT);
  assign bus.reg_we    = reg_we;
  assign bus.reg_dst   = reg_dst;
  assign bus.wsel      = wsel;
  assign bus.alu_x     = alu_x;
  assign bus.alu_y     = alu_y;
  assign bus.alu_y_imm = alu_y_imm;
  assign bus.out_we    = out_we;
  assign bus.out_src   = out_src;
  assign bus.illegal   = illegal;

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: ROM array, behavioral register file/adder,
// and a linear sequence of immediate-assertion checks.
module tb_cpu_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic force_en = 1'b1;
  logic force_carry = 1'b0;

  logic [15:0] rom [256];
  logic [7:0]  ra [4];
  logic [7:0]  x_val, y_val, wdata;
  logic [8:0]  sum9;

  int n_checks = 0;
  int n_err = 0;

  cpu_control_if bus();

  cpu_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.run       = run;
  assign bus.rom_data  = rom[bus.rom_addr];
  assign x_val         = ra[bus.alu_x];
  assign y_val         = bus.alu_y_imm ? bus.imm : ra[bus.alu_y];
  assign sum9          = {1'b0, x_val} + {1'b0, y_val};
  assign bus.alu_carry = force_en ? force_carry : sum9[8];
  assign wdata         = (bus.wsel == 2'b01) ? bus.imm :
                         (bus.wsel == 2'b10) ? ra[1] : sum9[7:0];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) ra[i] <= 8'h00;
    end else if (bus.reg_we) begin
      ra[bus.reg_dst] <= wdata;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  logic [7:0] outs[$];
  logic [7:0] fib_exp [13] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                               8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233};

  initial begin
    clear_rom();

    // MOV A,1 / OUT A decode and timing
    rom[0] = 16'h2201;
    rom[1] = 16'h2C00;
    run = 1'b1;
    do_reset();
    chk("rst_pc", {8'h00, bus.rom_addr}, 16'h0000);
    chk("rst_carry", {15'h0, bus.carry}, 16'h0);
    chk("rst_halted", {15'h0, bus.halted}, 16'h0);
    chk("rst_reg_we", {15'h0, bus.reg_we}, 16'h0);
    tick(1);
    chk("mov_reg_we", {15'h0, bus.reg_we}, 16'h1);
    chk("mov_dst", {14'h0, bus.reg_dst}, 16'h0);
    chk("mov_wsel", {14'h0, bus.wsel}, 16'h1);
    chk("mov_imm", {8'h00, bus.imm}, 16'h0001);
    chk("mov_out_we", {15'h0, bus.out_we}, 16'h0);
    tick(1);
    chk("fetch_reg_we", {15'h0, bus.reg_we}, 16'h0);
    chk("fetch_wsel", {14'h0, bus.wsel}, 16'h0);
    tick(1);
    chk("out_we", {15'h0, bus.out_we}, 16'h1);
    chk("out_src", {14'h0, bus.out_src}, 16'h0);
    chk("out_reg_we", {15'h0, bus.reg_we}, 16'h0);
    tick(1);
    chk("mov_out_pc", {8'h00, bus.rom_addr}, 16'h0002);

    // reset aborts an ADD in EXECUTE
    clear_rom();
    force_en = 1'b1;
    force_carry = 1'b1;
    do_reset();
    tick(1);
    chk("add_reg_we", {15'h0, bus.reg_we}, 16'h1);
    chk("add_x", {14'h0, bus.alu_x}, 16'h0);
    chk("add_y", {14'h0, bus.alu_y}, 16'h1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("abort_pc", {8'h00, bus.rom_addr}, 16'h0000);
    chk("abort_carry", {15'h0, bus.carry}, 16'h0);
    chk("abort_halted", {15'h0, bus.halted}, 16'h0);
    chk("abort_reg_we", {15'h0, bus.reg_we}, 16'h0);

    // ADD with carry then JNC: not taken
    rom[0] = 16'h0000;
    rom[1] = 16'h3010;
    force_carry = 1'b1;
    do_reset();
    tick(2);
    chk("add_carry_set", {15'h0, bus.carry}, 16'h1);
    tick(2);
    chk("jnc_nt_pc", {8'h00, bus.rom_addr}, 16'h0002);
    chk("jnc_keeps_carry", {15'h0, bus.carry}, 16'h1);

    // ADD without carry then JNC: taken
    force_carry = 1'b0;
    do_reset();
    tick(2);
    chk("add_carry_clr", {15'h0, bus.carry}, 16'h0);
    tick(2);
    chk("jnc_t_pc", {8'h00, bus.rom_addr}, 16'h0010);

    // run=0 stall in FETCH, then run ignored in EXECUTE
    clear_rom();
    rom[0] = 16'h2205;
    run = 1'b0;
    do_reset();
    tick(5);
    chk("stall_pc", {8'h00, bus.rom_addr}, 16'h0000);
    chk("stall_ir", {8'h00, bus.imm}, 16'h0000);
    chk("stall_reg_we", {15'h0, bus.reg_we}, 16'h0);
    run = 1'b1;
    tick(1);
    chk("unstall_imm", {8'h00, bus.imm}, 16'h0005);
    chk("unstall_reg_we", {15'h0, bus.reg_we}, 16'h1);
    run = 1'b0;
    tick(1);
    chk("exec_ignores_run_pc", {8'h00, bus.rom_addr}, 16'h0001);
    run = 1'b1;

    // undefined opcode at 0xFF: illegal pulse and pc wrap
    clear_rom();
    rom[0]   = 16'h34FF;
    rom[255] = 16'hFF00;
    do_reset();
    tick(2);
    chk("jmp_ff_pc", {8'h00, bus.rom_addr}, 16'h00FF);
    tick(1);
    chk("illegal_pulse", {15'h0, bus.illegal}, 16'h1);
    chk("illegal_reg_we", {15'h0, bus.reg_we}, 16'h0);
    tick(1);
    chk("illegal_clear", {15'h0, bus.illegal}, 16'h0);
    chk("wrap_pc", {8'h00, bus.rom_addr}, 16'h0000);

    // self-targeting JMP halts
    clear_rom();
    rom[0]  = 16'h340E;
    rom[14] = 16'h340E;
    do_reset();
    tick(2);
    chk("halt_jmp_pc", {8'h00, bus.rom_addr}, 16'h000E);
    tick(1);
    chk("halt_not_yet", {15'h0, bus.halted}, 16'h0);
    tick(1);
    chk("halted", {15'h0, bus.halted}, 16'h1);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("halt_pc_hold", {8'h00, bus.rom_addr}, 16'h000E);
      chk("halt_strobes", {13'h0, bus.reg_we, bus.out_we, bus.illegal}, 16'h0);
    end
    do_reset();
    chk("halt_rst_clear", {15'h0, bus.halted}, 16'h0);

    // Fibonacci program on the behavioral datapath
    clear_rom();
    rom[0]  = 16'h2201;
    rom[1]  = 16'h2300;
    rom[2]  = 16'h2700;
    rom[3]  = 16'h2C00;
    rom[4]  = 16'h0100;
    rom[5]  = 16'h3007;
    rom[6]  = 16'h340E;
    rom[7]  = 16'h2D00;
    rom[8]  = 16'h0000;
    rom[9]  = 16'h300B;
    rom[10] = 16'h340E;
    rom[11] = 16'h3801;
    rom[12] = 16'h3403;
    rom[14] = 16'h340E;
    force_en = 1'b0;
    outs.delete();
    do_reset();
    begin
      int cyc = 0;
      while (!bus.halted && cyc < 3000) begin
        if (bus.out_we) outs.push_back(ra[bus.out_src]);
        tick(1);
        cyc++;
      end
    end
    chk("fib_halted", {15'h0, bus.halted}, 16'h1);
    chk("fib_pc", {8'h00, bus.rom_addr}, 16'h000E);
    chk("fib_count", 16'(outs.size()), 16'd13);
    for (int i = 0; i < 13; i++) begin
      if (i < outs.size()) chk($sformatf("fib_out%0d", i), {8'h00, outs[i]}, {8'h00, fib_exp[i]});
      else chk($sformatf("fib_out%0d_missing", i), 16'hFFFF, {8'h00, fib_exp[i]});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_control.md
# cpu_control

Multi-cycle control unit for the 8-bit CPU. It owns the program counter, instruction register and carry flag, and fetches 16-bit instructions from the combinational program ROM. It decodes each instruction and drives register-file, ALU-operand and output-port strobes into the external datapath. Every instruction takes a FETCH cycle and an EXECUTE cycle, and a self-targeting JMP stops execution.

## Interface
- No parameters. Widths are fixed: 8-bit address, 16-bit instruction, 8-bit data.
- clk  in  1  single system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  fetch enable; sampled in FETCH only
- rom_addr  out  8  ROM address; always equals pc
- rom_data  in  16  ROM word, valid combinationally for rom_addr
- alu_carry  in  1  carry-out of the datapath adder for the current EXECUTE
- imm  out  8  ir[7:0], driven continuously
- reg_we  out  1  register write strobe (EXECUTE only)
- reg_dst  out  2  destination register: 00 A, 01 B, 10 C
- wsel  out  2  write data source: 00 adder sum, 01 imm, 10 register B
- alu_x  out  2  adder operand X register index (A/B/C encoding)
- alu_y  out  2  adder operand Y register index
- alu_y_imm  out  1  1 selects imm as operand Y instead of alu_y
- out_we  out  1  output port strobe (EXECUTE only)
- out_src  out  2  register driven to output port (A/B encoding)
- carry  out  1  current carry flag
- halted  out  1  high once a halt JMP has executed
- illegal  out  1  one-cycle pulse in EXECUTE of an undefined opcode

## Operation
- Opcode is ir[15:8] and operand is ir[7:0].
  - 0x00 ADD A,B: reg_we, dst A, wsel sum, x=A, y=B; carry updated
  - 0x01 ADD B,A: reg_we, dst B, wsel sum, x=B, y=A; carry updated
  - 0x22 MOV A,imm: reg_we, dst A, wsel imm
  - 0x23 MOV B,imm: reg_we, dst B, wsel imm
  - 0x27 MOV C,B: reg_we, dst C, wsel regB
  - 0x2C OUT A: out_we, out_src A
  - 0x2D OUT B: out_we, out_src B
  - 0x30 JNC imm: if carry==0, pc<=imm, else pc<=pc+1
  - 0x34 JMP imm: pc<=imm unconditionally
  - 0x38 INC C,imm: reg_we, dst C, wsel sum, x=C, alu_y_imm=1; carry updated
  - any other opcode: NOP, pc<=pc+1, illegal pulses
- Carry is updated only at the end of EXECUTE of ADD/INC (carry<=alu_carry). All other instructions preserve it.
- pc increments by 1 for all non-taken-branch instructions and wraps 0xFF->0x00.
- States:
  - FETCH: if run, ir<=rom_data and go to EXECUTE; otherwise hold all state.
  - EXECUTE: outputs decode ir; update pc and carry; go to FETCH, or go to HALT when a JMP or taken JNC targets its own address (imm==pc).
  - HALT: terminal. pc holds, halted=1, all strobes 0. Left only by rst.
- Outside EXECUTE: reg_we, out_we, illegal, alu_y_imm = 0; reg_dst, wsel, alu_x, alu_y, out_src = 0.

## Timing
- Reset (rst high at an edge): pc=0, ir=0, carry=0, state=FETCH, halted=0, all strobes 0 from the following cycle. rst overrides run and HALT and aborts any EXECUTE in progress, with no register write or pc update from that cycle.
- Each instruction takes 2 cycles when run=1. Datapath writes and carry/pc updates take effect on the edge that ends EXECUTE.
- Control outputs are decoded combinationally from ir and state. rom_addr is registered (pc).
- run=0 in FETCH stalls indefinitely. run is ignored in EXECUTE, so an instruction already latched always completes.
- JNC reads the carry value present at the start of its EXECUTE, so a JNC immediately after ADD sees that ADD's carry.
- halted rises on the edge ending the halting EXECUTE.

## Test plan
- Reset: drive rst for 2 cycles mid-EXECUTE of ADD -> pc=0, carry=0, halted=0, reg_we=0 next cycle, and no carry update.
- MOV/OUT decode: ROM[0]=0x2201, ROM[1]=0x2C00 -> cycle 1 reg_we=1, dst=00, wsel=01, imm=0x01; cycle 3 out_we=1, out_src=00; pc=2 after 4 cycles.
- JNC: ADD with alu_carry=1, then JNC 0x10 -> pc=ADD+2. Repeat with alu_carry=0 -> pc=0x10.
- Stall and wrap: run=0 for 5 cycles in FETCH -> pc and ir unchanged. NOP (0xFF00) at pc 0xFF -> illegal pulses, pc=0x00.
- Halt: JMP 0x0E at address 0x0E -> halted=1, pc stays 0x0E for 20 further cycles, and no strobes.
- Fibonacci program (MOV A,1; MOV B,0; MOV C,B; ADD/JNC/INC/OUT loop; JMP 14 at 14) with a behavioral register file and adder -> out port sequence 1,1,2,3,5,8,13,21,34,55,89,144,233, then halted with pc=0x0E.
